// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 program-counter unit: next-PC mode
// encodings and the sequential instruction step.
package legv8_pkg;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_LOAD = 2'b10,
    PC_REL  = 2'b11
  } pc_sel_e;

  localparam int unsigned PC_STEP = 32'd4;

endpackage

// File: rtl/legv8_link_stack.sv
// Circular link (return-address) stack. A push onto a full stack overwrites
// the oldest entry; push+pop on a non-empty stack replaces the top in place;
// push+pop on an empty stack degrades to a plain push.
module legv8_link_stack
  import legv8_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [STACK_DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] ptr_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [PTR_W-1:0] wr_idx_s;
  logic             wr_en_s;
  logic             empty_s;
  logic             full_s;

  assign empty_s  = (cnt_r == {CNT_W{1'b0}});
  assign full_s   = (cnt_r == CNT_W'(STACK_DEPTH));
  assign empty    = empty_s;
  assign full     = full_s;
  assign top_data = empty_s ? {WIDTH{1'b0}} : mem_r[ptr_r];

  // Decide pointer/count movement and which slot (if any) gets written.
  always_comb begin
    ptr_nxt_s = ptr_r;
    cnt_nxt_s = cnt_r;
    wr_idx_s  = ptr_r;
    wr_en_s   = 1'b0;
    if (push && pop && !empty_s) begin
      // replace top in place, count unchanged
      wr_en_s = 1'b1;
    end else if (push) begin
      // plain push (also covers push+pop on empty); saturate the count
      ptr_nxt_s = ptr_r + PTR_W'(1);
      wr_idx_s  = ptr_r + PTR_W'(1);
      wr_en_s   = 1'b1;
      if (!full_s) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (pop && !empty_s) begin
      ptr_nxt_s = ptr_r - PTR_W'(1);
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Entry storage; contents are don't-care after reset since count gates reads.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

endmodule

// File: rtl/legv8_pc_unit.sv
// LEGv8 program-counter unit: registered PC with hold/increment/load/relative
// modes, a link stack for BL/RET, and sticky overflow/underflow/alignment flags.
module legv8_pc_unit
  import legv8_pkg::*;
#(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter int               STACK_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_en,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] in_addr,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] ret_top,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             err_align
);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_nxt_s;
  logic [WIDTH-1:0] target_s;
  logic             ovf_r;
  logic             unf_r;
  logic             align_r;
  logic             set_ovf_s;
  logic             set_unf_s;
  logic             set_align_s;
  logic             stk_push_s;
  logic             stk_pop_s;
  logic             empty_s;
  logic             full_s;
  logic [WIDTH-1:0] top_s;

  assign pc_plus4   = pc_r + WIDTH'(PC_STEP);
  assign stk_push_s = pc_en & push;
  assign stk_pop_s  = pc_en & pop;

  legv8_link_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_link_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (stk_push_s),
    .pop      (stk_pop_s),
    .wr_data  (pc_plus4),
    .top_data (top_s),
    .empty    (empty_s),
    .full     (full_s)
  );

  // Next-PC selection, target alignment fix-up and error-flag set conditions.
  always_comb begin
    pc_nxt_s    = pc_r;
    target_s    = {WIDTH{1'b0}};
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    set_align_s = 1'b0;
    if (!pc_en) begin
      pc_nxt_s = pc_r;
    end else if (pop) begin
      if (empty_s) begin
        pc_nxt_s  = pc_r;
        set_unf_s = 1'b1;
      end else begin
        pc_nxt_s = top_s;
      end
    end else begin
      set_ovf_s = push & full_s;
      case (pc_sel)
        PC_HOLD: pc_nxt_s = pc_r;
        PC_INC:  pc_nxt_s = pc_plus4;
        PC_LOAD: target_s = in_addr;
        PC_REL:  target_s = pc_r + in_addr;
        default: pc_nxt_s = pc_r;
      endcase
      if (pc_sel == PC_LOAD || pc_sel == PC_REL) begin
        pc_nxt_s    = {target_s[WIDTH-1:2], 2'b00};
        set_align_s = (target_s[1:0] != 2'b00);
      end else begin
        set_align_s = 1'b0;
      end
    end
  end

  // PC register and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r    <= RESET_VECTOR;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      align_r <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      ovf_r   <= ovf_r | set_ovf_s;
      unf_r   <= unf_r | set_unf_s;
      align_r <= align_r | set_align_s;
    end
  end

  assign pc_out      = pc_r;
  assign ret_top     = top_s;
  assign stack_empty = empty_s;
  assign stack_full  = full_s;
  assign err_ovf     = ovf_r;
  assign err_unf     = unf_r;
  assign err_align   = align_r;

endmodule

// File: tb/tb_legv8_pc_unit.sv
// Directed testbench for legv8_pc_unit (RESET_VECTOR=0x100, STACK_DEPTH=4).
module tb_legv8_pc_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_en = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [63:0] in_addr = 64'h0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [63:0] pc_out, pc_plus4, ret_top;
  logic        stack_empty, stack_full, err_ovf, err_unf, err_align;

  int vectors = 0;
  int miscompares = 0;

  legv8_pc_unit #(
    .WIDTH        (64),
    .RESET_VECTOR (64'h100),
    .STACK_DEPTH  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .in_addr     (in_addr),
    .push        (push),
    .pop         (pop),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .ret_top     (ret_top),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf),
    .err_align   (err_align)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [1:0] sel, input logic [63:0] addr,
                      input logic ps, input logic pp);
    pc_en = en; pc_sel = sel; in_addr = addr; push = ps; pop = pp;
    @(posedge clock);
    #1;
    pc_en = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", pc_out, 64'h100);
    chk("rst_empty", {63'd0, stack_empty}, 64'd1);
    chk("rst_full", {63'd0, stack_full}, 64'd0);
    chk("rst_top", ret_top, 64'h0);
    chk("rst_flags", {61'd0, err_ovf, err_unf, err_align}, 64'd0);
    reset = 1'b0;

    // Sequential increment
    step(1'b1, 2'b01, 64'h0, 1'b0, 1'b0); chk("inc1", pc_out, 64'h104);
    step(1'b1, 2'b01, 64'h0, 1'b0, 1'b0); chk("inc2", pc_out, 64'h108);
    step(1'b1, 2'b01, 64'h0, 1'b0, 1'b0); chk("inc3", pc_out, 64'h10C);
    chk("plus4", pc_plus4, 64'h110);

    // Hold mode
    step(1'b1, 2'b00, 64'h0, 1'b0, 1'b0); chk("hold", pc_out, 64'h10C);

    // Load, relative with negative offset, misaligned load
    step(1'b1, 2'b10, 64'h200, 1'b0, 1'b0); chk("load", pc_out, 64'h200);
    chk("align_clean", {63'd0, err_align}, 64'd0);
    step(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0); chk("rel_neg", pc_out, 64'h1F0);
    step(1'b1, 2'b10, 64'h402, 1'b0, 1'b0); chk("load_mis", pc_out, 64'h400);
    chk("align_set", {63'd0, err_align}, 64'd1);
    step(1'b1, 2'b01, 64'h0, 1'b0, 1'b0); chk("align_sticky", {63'd0, err_align}, 64'd1);

    // Asynchronous reset mid-sequence: visible before the next edge
    #2 reset = 1'b1;
    #1;
    chk("async_pc", pc_out, 64'h100);
    chk("async_flags", {61'd0, err_ovf, err_unf, err_align}, 64'd0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_hold", pc_out, 64'h100);

    // BL / RET
    step(1'b1, 2'b10, 64'h1000, 1'b0, 1'b0); chk("ld1000", pc_out, 64'h1000);
    step(1'b1, 2'b10, 64'h2000, 1'b1, 1'b0); chk("bl_pc", pc_out, 64'h2000);
    chk("bl_top", ret_top, 64'h1004);
    chk("bl_nonempty", {63'd0, stack_empty}, 64'd0);
    step(1'b1, 2'b01, 64'h0, 1'b0, 1'b1); chk("ret_pc", pc_out, 64'h1004);
    chk("ret_empty", {63'd0, stack_empty}, 64'd1);

    // Wrap-around
    step(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0); chk("ld_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 2'b01, 64'h0, 1'b0, 1'b0); chk("wrap", pc_out, 64'h0);

    // Overflow: five pushes from 0x0..0x10
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 64'h0, 1'b1, 1'b0);
    chk("ovf_pc", pc_out, 64'h14);
    chk("ovf_full", {63'd0, stack_full}, 64'd1);
    chk("ovf_flag", {63'd0, err_ovf}, 64'd1);
    chk("ovf_top", ret_top, 64'h14);
    step(1'b1, 2'b10, 64'h0, 1'b0, 1'b1); chk("pop1", pc_out, 64'h14);
    step(1'b1, 2'b10, 64'h0, 1'b0, 1'b1); chk("pop2", pc_out, 64'h10);
    step(1'b1, 2'b10, 64'h0, 1'b0, 1'b1); chk("pop3", pc_out, 64'hC);
    step(1'b1, 2'b10, 64'h0, 1'b0, 1'b1); chk("pop4", pc_out, 64'h8);
    chk("unf_clean", {63'd0, err_unf}, 64'd0);
    step(1'b1, 2'b10, 64'h0, 1'b0, 1'b1); chk("pop5_hold", pc_out, 64'h8);
    chk("unf_set", {63'd0, err_unf}, 64'd1);
    chk("pop5_empty", {63'd0, stack_empty}, 64'd1);

    // Disabled: push ignored, nothing changes
    step(1'b0, 2'b01, 64'h0, 1'b1, 1'b0); chk("dis_pc", pc_out, 64'h8);
    chk("dis_empty", {63'd0, stack_empty}, 64'd1);
    chk("dis_top", ret_top, 64'h0);

    // Push+pop on non-empty stack: top 0x500 at PC 0x3000
    step(1'b1, 2'b10, 64'h4FC, 1'b0, 1'b0);
    step(1'b1, 2'b10, 64'h3000, 1'b1, 1'b0); chk("pp_setup_top", ret_top, 64'h500);
    step(1'b1, 2'b01, 64'h0, 1'b1, 1'b1); chk("pp_pc", pc_out, 64'h500);
    chk("pp_top", ret_top, 64'h3004);
    step(1'b1, 2'b00, 64'h0, 1'b0, 1'b1); chk("pp_count1", pc_out, 64'h3004);
    chk("pp_count_empty", {63'd0, stack_empty}, 64'd1);

    // Push+pop on empty stack: hold, push still happens
    step(1'b1, 2'b01, 64'h0, 1'b1, 1'b1); chk("ppe_pc", pc_out, 64'h3004);
    chk("ppe_top", ret_top, 64'h3008);
    chk("ppe_nonempty", {63'd0, stack_empty}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
